// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and EX-stage operand path for the RV32 5-stage core.
// Captures decoded ID fields, decodes the ALU opcode at capture time, bypasses
// WB data into the captured register values, forwards EX/MEM and MEM/WB
// results into the ALU operands, and detects load-use hazards.
// Optional feature macro: ALU_DECODE_ERR_EN (registered decode-error flag).
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [2:0]        id_funct3_i,
    input  logic              id_funct7_b5_i,
    input  logic [1:0]        id_alu_op_i,
    input  logic              id_alu_src_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic              id_mem_to_reg_i,
    input  logic              id_branch_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [XLEN-1:0]   exmem_alu_out_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]   memwb_wdata_i,
    output logic              hazard_stall_o,
    output logic              ex_valid_o,
    output logic [3:0]        ex_alu_opcode_o,
    output logic [XLEN-1:0]   ex_in_a_o,
    output logic [XLEN-1:0]   ex_in_b_o,
    output logic [XLEN-1:0]   ex_store_data_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic              ex_mem_to_reg_o,
    output logic              ex_branch_o,
    output logic              ex_decode_err_o
);

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h6;

    typedef enum logic [1:0] {
        UPD_LOAD   = 2'd0,
        UPD_HOLD   = 2'd1,
        UPD_BUBBLE = 2'd2
    } upd_e;

    upd_e              upd;

    logic              valid_q,      valid_d;
    logic [3:0]        opcode_q,     opcode_d;
    logic              reg_write_q,  reg_write_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              branch_q,     branch_d;
    logic              alu_src_q,    alu_src_d;
    logic [REG_AW-1:0] rd_q,         rd_d;
    logic [REG_AW-1:0] rs1_q,        rs1_d;
    logic [REG_AW-1:0] rs2_q,        rs2_d;
    logic [XLEN-1:0]   rs1_data_q,   rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q,   rs2_data_d;
    logic [XLEN-1:0]   imm_q,        imm_d;

    logic [3:0]        dec_opcode;
    logic              wb_byp_rs1;
    logic              wb_byp_rs2;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;

    // Load-use: a load in EX whose destination is read by the instruction in ID.
    assign hazard_stall_o = id_valid_i && valid_q && mem_read_q && (rd_q != '0) &&
                            ((rd_q == id_rs1_i) || (rd_q == id_rs2_i));

    // Update selection: flush beats external stall, which beats the hazard bubble.
    always_comb begin
        if (flush_i) begin
            upd = UPD_BUBBLE;
        end else if (stall_i) begin
            upd = UPD_HOLD;
        end else if (hazard_stall_o) begin
            upd = UPD_BUBBLE;
        end else begin
            upd = UPD_LOAD;
        end
    end

    // ALU control decode of the instruction currently in ID.
    always_comb begin
        dec_opcode = OP_ADD;
        case (id_alu_op_i)
            2'b00: dec_opcode = OP_ADD;
            2'b01: dec_opcode = OP_SUB;
            default: begin
                case (id_funct3_i)
                    3'b000:  dec_opcode = ((id_alu_op_i == 2'b10) && id_funct7_b5_i) ? OP_SUB : OP_ADD;
                    3'b111:  dec_opcode = OP_AND;
                    3'b110:  dec_opcode = OP_OR;
                    default: dec_opcode = OP_ADD;
                endcase
            end
        endcase
    end

    // A write landing in the register file this cycle is not yet visible in the
    // ID read data, so take it directly from the WB stage at capture.
    assign wb_byp_rs1 = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == id_rs1_i);
    assign wb_byp_rs2 = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == id_rs2_i);

    // Next-state for the ID/EX register; bubbles clear the control path only.
    always_comb begin
        valid_d      = valid_q;
        opcode_d     = opcode_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        branch_d     = branch_q;
        alu_src_d    = alu_src_q;
        rd_d         = rd_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        imm_d        = imm_q;
        case (upd)
            UPD_BUBBLE: begin
                valid_d      = 1'b0;
                opcode_d     = OP_ADD;
                reg_write_d  = 1'b0;
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
                mem_to_reg_d = 1'b0;
                branch_d     = 1'b0;
            end
            UPD_LOAD: begin
                valid_d      = id_valid_i;
                opcode_d     = dec_opcode;
                reg_write_d  = id_reg_write_i;
                mem_read_d   = id_mem_read_i;
                mem_write_d  = id_mem_write_i;
                mem_to_reg_d = id_mem_to_reg_i;
                branch_d     = id_branch_i;
                alu_src_d    = id_alu_src_i;
                rd_d         = id_rd_i;
                rs1_d        = id_rs1_i;
                rs2_d        = id_rs2_i;
                rs1_data_d   = wb_byp_rs1 ? memwb_wdata_i : id_rs1_data_i;
                rs2_data_d   = wb_byp_rs2 ? memwb_wdata_i : id_rs2_data_i;
                imm_d        = id_imm_i;
            end
            default: ;
        endcase
    end

    // ID/EX register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q      <= 1'b0;
            opcode_q     <= OP_ADD;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            branch_q     <= 1'b0;
            alu_src_q    <= 1'b0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            opcode_q     <= opcode_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            branch_q     <= branch_d;
            alu_src_q    <= alu_src_d;
            rd_q         <= rd_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
        end
    end

    // Operand forwarding: the younger EX/MEM result wins over MEM/WB; x0 never forwards.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs1_q)) begin
            fwd_rs1 = exmem_alu_out_i;
        end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs1_q)) begin
            fwd_rs1 = memwb_wdata_i;
        end
    end

    // Same priority for rs2, which feeds both in_b and the store data.
    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs2_q)) begin
            fwd_rs2 = exmem_alu_out_i;
        end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs2_q)) begin
            fwd_rs2 = memwb_wdata_i;
        end
    end

    assign ex_in_a_o       = fwd_rs1;
    assign ex_in_b_o       = alu_src_q ? imm_q : fwd_rs2;
    assign ex_store_data_o = fwd_rs2;
    assign ex_valid_o      = valid_q;
    assign ex_alu_opcode_o = opcode_q;
    assign ex_rd_o         = rd_q;
    assign ex_reg_write_o  = reg_write_q;
    assign ex_mem_read_o   = mem_read_q;
    assign ex_mem_write_o  = mem_write_q;
    assign ex_mem_to_reg_o = mem_to_reg_q;
    assign ex_branch_o     = branch_q;

`ifdef ALU_DECODE_ERR_EN
    logic dec_illegal;
    logic dec_err_q, dec_err_d;

    // R/I-type funct3 values the ALU control does not implement.
    assign dec_illegal = id_alu_op_i[1] &&
                         !((id_funct3_i == 3'b000) || (id_funct3_i == 3'b110) || (id_funct3_i == 3'b111));

    // Error flag follows the instruction through the same update rules.
    always_comb begin
        dec_err_d = dec_err_q;
        case (upd)
            UPD_LOAD:   dec_err_d = dec_illegal;
            UPD_BUBBLE: dec_err_d = 1'b0;
            default:    ;
        endcase
    end

    // Decode-error register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dec_err_q <= 1'b0;
        end else begin
            dec_err_q <= dec_err_d;
        end
    end

    assign ex_decode_err_o = dec_err_q;
`else
    assign ex_decode_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
`ifdef ALU_DECODE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall, flush, id_valid;
    logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic [2:0]        id_funct3;
    logic              id_funct7_b5;
    logic [1:0]        id_alu_op;
    logic              id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic              exmem_reg_write;
    logic [REG_AW-1:0] exmem_rd;
    logic [XLEN-1:0]   exmem_alu_out;
    logic              memwb_reg_write;
    logic [REG_AW-1:0] memwb_rd;
    logic [XLEN-1:0]   memwb_wdata;
    logic              hazard_stall, ex_valid;
    logic [3:0]        ex_alu_opcode;
    logic [XLEN-1:0]   ex_in_a, ex_in_b, ex_store_data;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_decode_err;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush), .id_valid_i(id_valid),
        .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_funct3_i(id_funct3), .id_funct7_b5_i(id_funct7_b5), .id_alu_op_i(id_alu_op),
        .id_alu_src_i(id_alu_src), .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
        .id_mem_write_i(id_mem_write), .id_mem_to_reg_i(id_mem_to_reg), .id_branch_i(id_branch),
        .exmem_reg_write_i(exmem_reg_write), .exmem_rd_i(exmem_rd), .exmem_alu_out_i(exmem_alu_out),
        .memwb_reg_write_i(memwb_reg_write), .memwb_rd_i(memwb_rd), .memwb_wdata_i(memwb_wdata),
        .hazard_stall_o(hazard_stall), .ex_valid_o(ex_valid), .ex_alu_opcode_o(ex_alu_opcode),
        .ex_in_a_o(ex_in_a), .ex_in_b_o(ex_in_b), .ex_store_data_o(ex_store_data), .ex_rd_o(ex_rd),
        .ex_reg_write_o(ex_reg_write), .ex_mem_read_o(ex_mem_read), .ex_mem_write_o(ex_mem_write),
        .ex_mem_to_reg_o(ex_mem_to_reg), .ex_branch_o(ex_branch), .ex_decode_err_o(ex_decode_err)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model: what instruction sits in EX ----------------
    logic              m_valid, m_src, m_rw, m_mr, m_mw, m_m2r, m_br, m_err;
    logic [3:0]        m_op;
    logic [REG_AW-1:0] m_rd, m_rs1, m_rs2;
    logic [XLEN-1:0]   m_d1, m_d2, m_imm;

    function automatic logic [3:0] alu_meaning(input logic [1:0] aop, input logic [2:0] f3, input logic b5);
        if (aop == 2'b00) return 4'h2;
        if (aop == 2'b01) return 4'h6;
        if (f3 == 3'b000) return (aop == 2'b10 && b5) ? 4'h6 : 4'h2;
        if (f3 == 3'b111) return 4'h0;
        if (f3 == 3'b110) return 4'h1;
        return 4'h2;
    endfunction

    function automatic logic illegal_f3(input logic [1:0] aop, input logic [2:0] f3);
        return ERR_EN && (aop >= 2'd2) && !(f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd7);
    endfunction

    // Value the ALU should see for a register: youngest in-flight writer, else captured data.
    function automatic logic [XLEN-1:0] newest(input logic [REG_AW-1:0] r, input logic [XLEN-1:0] cap);
        if (r == 0) return cap;
        if (exmem_reg_write && exmem_rd == r) return exmem_alu_out;
        if (memwb_reg_write && memwb_rd == r) return memwb_wdata;
        return cap;
    endfunction

    function automatic logic load_use();
        return id_valid && m_valid && m_mr && (m_rd != 0) && (m_rd == id_rs1 || m_rd == id_rs2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_src <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0; m_m2r <= 0; m_br <= 0;
            m_err <= 0; m_op <= 4'h2; m_rd <= 0; m_rs1 <= 0; m_rs2 <= 0;
            m_d1 <= 0; m_d2 <= 0; m_imm <= 0;
        end else if (flush || (!stall && load_use())) begin
            m_valid <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0; m_m2r <= 0; m_br <= 0;
            m_err <= 0; m_op <= 4'h2;
        end else if (!stall) begin
            m_valid <= id_valid; m_src <= id_alu_src; m_rw <= id_reg_write; m_mr <= id_mem_read;
            m_mw <= id_mem_write; m_m2r <= id_mem_to_reg; m_br <= id_branch;
            m_op <= alu_meaning(id_alu_op, id_funct3, id_funct7_b5);
            m_err <= illegal_f3(id_alu_op, id_funct3);
            m_rd <= id_rd; m_rs1 <= id_rs1; m_rs2 <= id_rs2; m_imm <= id_imm;
            m_d1 <= (memwb_reg_write && memwb_rd != 0 && memwb_rd == id_rs1) ? memwb_wdata : id_rs1_data;
            m_d2 <= (memwb_reg_write && memwb_rd != 0 && memwb_rd == id_rs2) ? memwb_wdata : id_rs2_data;
        end
    end

    // Compare process: once per cycle, mid-low-phase, after inputs have settled.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("m_valid", 32'(ex_valid), 32'(m_valid));
            chk("m_opcode", 32'(ex_alu_opcode), 32'(m_op));
            chk("m_ctrl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch},
                {27'd0, m_rw, m_mr, m_mw, m_m2r, m_br});
            chk("m_hazard", 32'(hazard_stall), 32'(load_use()));
            chk("m_decerr", 32'(ex_decode_err), 32'(m_err));
            if (m_valid) begin
                chk("m_rd", 32'(ex_rd), 32'(m_rd));
                chk("m_in_a", ex_in_a, newest(m_rs1, m_d1));
                chk("m_store", ex_store_data, newest(m_rs2, m_d2));
                chk("m_in_b", ex_in_b, m_src ? m_imm : newest(m_rs2, m_d2));
            end
        end
    end

    task automatic idle_inputs();
        stall = 0; flush = 0; id_valid = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_funct3 = 0; id_funct7_b5 = 0; id_alu_op = 0; id_alu_src = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0; id_branch = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_alu_out = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_wdata = 0;
    endtask

    task automatic rtype(input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                         input logic [REG_AW-1:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [1:0] aop, input logic [2:0] f3, input logic b5);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1; id_rs2_data = d2;
        id_alu_op = aop; id_funct3 = f3; id_funct7_b5 = b5; id_alu_src = 0; id_imm = 0;
        id_reg_write = 1; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0; id_branch = 0;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        #12;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_opcode", 32'(ex_alu_opcode), 32'h2);
        chk("rst_ctrl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}, 32'd0);
        chk("rst_hazard", 32'(hazard_stall), 32'd0);
        chk("rst_decerr", 32'(ex_decode_err), 32'd0);
        chk("rst_in_a", ex_in_a, 32'd0);
        @(negedge clk); rst_n = 1; chk_en = 1;

        // ADD 5 + 7
        rtype(5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 2'b10, 3'b000, 1'b0);
        @(posedge clk); #1;
        chk("add_opcode", 32'(ex_alu_opcode), 32'h2);
        chk("add_in_a", ex_in_a, 32'd5);
        chk("add_in_b", ex_in_b, 32'd7);
        chk("add_valid", 32'(ex_valid), 32'd1);

        // SUB with rs1=x3 produced in both EX/MEM and MEM/WB
        @(negedge clk);
        rtype(5'd3, 5'd2, 5'd6, 32'd11, 32'd7, 2'b10, 3'b000, 1'b1);
        @(posedge clk); #1;
        exmem_reg_write = 1; exmem_rd = 5'd3; exmem_alu_out = 32'd100;
        memwb_reg_write = 1; memwb_rd = 5'd3; memwb_wdata = 32'd50;
        #1;
        chk("sub_opcode", 32'(ex_alu_opcode), 32'h6);
        chk("fwd_exmem_prio", ex_in_a, 32'd100);
        exmem_reg_write = 0; #1;
        chk("fwd_memwb", ex_in_a, 32'd50);

        // rs1 = x0 never forwarded
        @(negedge clk);
        idle_inputs();
        rtype(5'd0, 5'd2, 5'd7, 32'd17, 32'd7, 2'b10, 3'b000, 1'b0);
        @(posedge clk); #1;
        exmem_reg_write = 1; exmem_rd = 5'd0; exmem_alu_out = 32'd99;
        memwb_reg_write = 1; memwb_rd = 5'd0; memwb_wdata = 32'd88;
        #1;
        chk("x0_no_fwd", ex_in_a, 32'd17);

        // Load rd=x4 followed by a consumer of x4
        @(negedge clk);
        idle_inputs();
        id_valid = 1; id_rs1 = 5'd1; id_rd = 5'd4; id_imm = 32'h40; id_alu_src = 1;
        id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
        @(negedge clk);
        idle_inputs();
        rtype(5'd1, 5'd4, 5'd8, 32'd1, 32'd2, 2'b10, 3'b000, 1'b0);
        #1;
        chk("loaduse_hazard", 32'(hazard_stall), 32'd1);
        @(posedge clk); #1;
        chk("loaduse_bubble_valid", 32'(ex_valid), 32'd0);
        chk("loaduse_bubble_ctrl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}, 32'd0);
        chk("loaduse_one_cycle", 32'(hazard_stall), 32'd0);

        // Stall holds for three cycles, then flush beats stall
        @(negedge clk);
        idle_inputs();
        rtype(5'd1, 5'd2, 5'd6, 32'h10, 32'h20, 2'b11, 3'b111, 1'b0);
        id_alu_src = 1; id_imm = 32'h30;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1;
            rtype(5'(i + 9), 5'(i + 10), 5'd12, $urandom, $urandom, 2'b10, 3'b110, 1'b1);
            @(posedge clk); #1;
            chk("stall_valid", 32'(ex_valid), 32'd1);
            chk("stall_opcode", 32'(ex_alu_opcode), 32'h0);
            chk("stall_in_a", ex_in_a, 32'h10);
            chk("stall_in_b", ex_in_b, 32'h30);
            chk("stall_store", ex_store_data, 32'h20);
            chk("stall_rd", 32'(ex_rd), 32'd6);
        end
        @(negedge clk);
        flush = 1; stall = 1;
        @(posedge clk); #1;
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_rw", 32'(ex_reg_write), 32'd0);
        chk("flush_opcode", 32'(ex_alu_opcode), 32'h2);

        // Unsupported funct3 on an I-type ALU op
        @(negedge clk);
        idle_inputs();
        rtype(5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 2'b11, 3'b001, 1'b0);
        @(posedge clk); #1;
        chk("decerr_opcode", 32'(ex_alu_opcode), 32'h2);
        chk("decerr_flag", 32'(ex_decode_err), 32'(ERR_EN));

        // Randomized traffic on a small register window to provoke hits
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            id_valid        = ($urandom_range(0, 9) != 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_rd           = 5'($urandom_range(0, 3));
            id_rs1_data     = $urandom;
            id_rs2_data     = $urandom;
            id_imm          = $urandom;
            id_funct3       = 3'($urandom_range(0, 7));
            id_funct7_b5    = 1'($urandom_range(0, 1));
            id_alu_op       = 2'($urandom_range(0, 3));
            id_alu_src      = 1'($urandom_range(0, 1));
            id_reg_write    = 1'($urandom_range(0, 1));
            id_mem_read     = ($urandom_range(0, 2) == 0);
            id_mem_write    = 1'($urandom_range(0, 1));
            id_mem_to_reg   = 1'($urandom_range(0, 1));
            id_branch       = 1'($urandom_range(0, 1));
            exmem_reg_write = 1'($urandom_range(0, 1));
            exmem_rd        = 5'($urandom_range(0, 3));
            exmem_alu_out   = $urandom;
            memwb_reg_write = 1'($urandom_range(0, 1));
            memwb_rd        = 5'($urandom_range(0, 3));
            memwb_wdata     = $urandom;
            stall           = ($urandom_range(0, 9) == 0);
            flush           = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
